// File: rtl/max_sched_pkg.sv
// Shared types and constants for the 64-lane max-tree row scheduler.
package max_sched_pkg;

    localparam int DATA_W     = 16;
    localparam int LANES      = 64;
    localparam int TREE_LAT   = 6;
    localparam int TAG_STAGES = TREE_LAT + 1;

    localparam logic [15:0] NEG_INF = 16'h8000;

    typedef enum logic [1:0] {
        MODE_64 = 2'd0,
        MODE_32 = 2'd1,
        MODE_16 = 2'd2
    } mode_e;

    typedef struct packed {
        logic  valid;
        logic  last;
        mode_e mode;
    } tag_t;

    // Unknown encodings fall back to the full 64-lane reduction.
    function automatic mode_e decode_mode(input logic [3:0] m);
        case (m)
            4'd1:    return MODE_32;
            4'd2:    return MODE_16;
            default: return MODE_64;
        endcase
    endfunction

endpackage

// File: rtl/max_sched_fifo.sv
// Result FIFO: registered storage, combinational head, occupancy count.
module max_sched_fifo
    import max_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (cnt_q == CW'(DEPTH));
        empty_o = (cnt_q == '0);
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full | do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Upstream credit accounting must make this unreachable.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            a_no_push_full: assert (!(push_i && full && !pop_i));
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/max_tree_sched.sv
// Row scheduler for the 64-lane max tree: pads and drives beats, tags them
// through the tree latency, folds multi-beat rows and queues row maxima.
module max_tree_sched
    import max_sched_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LANES      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [LANES*DATA_W-1:0]    i_in_data,
    input  logic [LANES-1:0]           i_in_mask,
    input  logic                       i_in_last,
    input  logic [3:0]                 i_in_mode,
    output logic                       o_tree_en,
    output logic [3:0]                 o_tree_length_mode,
    output logic [LANES-1:0]           o_tree_valid,
    output logic [LANES*DATA_W-1:0]    o_tree_in_flat,
    input  logic                       i_tree_valid_max,
    input  logic signed [DATA_W-1:0]   i_tree_max64_0,
    input  logic signed [DATA_W-1:0]   i_tree_max32_0,
    input  logic signed [DATA_W-1:0]   i_tree_max32_1,
    input  logic signed [DATA_W-1:0]   i_tree_max16_0,
    input  logic signed [DATA_W-1:0]   i_tree_max16_1,
    input  logic signed [DATA_W-1:0]   i_tree_max16_2,
    input  logic signed [DATA_W-1:0]   i_tree_max16_3,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [4*DATA_W-1:0]        o_out_max,
    output logic [2:0]                 o_out_cnt,
    output logic                       o_busy,
    output logic                       o_err
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int LCW   = $clog2(TAG_STAGES + 1);
    localparam int RES_W = 4 * DATA_W + 3;
    localparam logic signed [DATA_W-1:0] PAD_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic                      en_q;
    logic                      row_open_q, row_open_d;
    mode_e                     row_mode_q, row_mode_d;
    logic                      err_q, err_d;
    logic [LANES*DATA_W-1:0]   tree_data_q, tree_data_d;
    logic                      tree_vld_q;
    mode_e                     tree_mode_q;
    tag_t                      tag_q [TAG_STAGES];
    tag_t                      tag_d0;
    tag_t                      out_tag;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic                      acc_vld_q, acc_vld_d;
    logic signed [DATA_W-1:0]  m64;

    logic                      accept;
    mode_e                     cur_mode;
    logic                      eff_last;
    logic                      mode_bad;
    logic                      last_bad;
    logic                      any_tag;
    logic [LCW-1:0]            last_inflight;
    logic [CW:0]               credit_used;

    logic                      push;
    logic [RES_W-1:0]          push_data;
    logic [RES_W-1:0]          head;
    logic [CW-1:0]             fifo_cnt;
    logic                      fifo_empty;

    // ---- input side: credits, mode capture, lane padding ----
    always_comb begin
        last_inflight = '0;
        any_tag       = 1'b0;
        for (int s = 0; s < TAG_STAGES; s++) begin
            any_tag = any_tag | tag_q[s].valid;
            if (tag_q[s].valid && tag_q[s].last) begin
                last_inflight = last_inflight + 1'b1;
            end
        end
        credit_used = {1'b0, fifo_cnt} + (CW+1)'(last_inflight);
        // Ready ignores the offered beat, so non-last beats also wait for a credit.
        o_in_ready  = en_q & (credit_used < (CW+1)'(FIFO_DEPTH));
        accept      = i_in_valid & o_in_ready;

        cur_mode = row_open_q ? row_mode_q : decode_mode(i_in_mode);
        mode_bad = !row_open_q && (i_in_mode > 4'd2);
        eff_last = i_in_last || (cur_mode != MODE_64);
        last_bad = !i_in_last && (cur_mode != MODE_64);

        tree_data_d = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_data_d[i*DATA_W +: DATA_W] =
                i_in_mask[i] ? i_in_data[i*DATA_W +: DATA_W] : PAD_VAL;
        end

        row_open_d = accept ? !eff_last : row_open_q;
        row_mode_d = (accept && !row_open_q) ? cur_mode : row_mode_q;

        tag_d0 = '0;
        if (accept) begin
            tag_d0.valid = 1'b1;
            tag_d0.last  = eff_last;
            tag_d0.mode  = cur_mode;
        end
    end

    // ---- output side: row folding and FIFO push ----
    always_comb begin
        out_tag   = tag_q[TAG_STAGES-1];
        m64       = acc_vld_q ? smax(acc_q, i_tree_max64_0) : i_tree_max64_0;
        acc_d     = acc_q;
        acc_vld_d = acc_vld_q;
        push      = 1'b0;
        push_data = '0;
        if (out_tag.valid) begin
            case (out_tag.mode)
                MODE_32: begin
                    push      = 1'b1;
                    push_data = {3'd2, {(2*DATA_W){1'b0}}, i_tree_max32_1, i_tree_max32_0};
                end
                MODE_16: begin
                    push      = 1'b1;
                    push_data = {3'd4, i_tree_max16_3, i_tree_max16_2,
                                 i_tree_max16_1, i_tree_max16_0};
                end
                default: begin
                    if (out_tag.last) begin
                        push      = 1'b1;
                        push_data = {3'd1, {(3*DATA_W){1'b0}}, m64};
                        acc_vld_d = 1'b0;
                    end else begin
                        acc_d     = m64;
                        acc_vld_d = 1'b1;
                    end
                end
            endcase
        end

        err_d = err_q | (accept & (mode_bad | last_bad)) |
                (out_tag.valid != i_tree_valid_max);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q        <= 1'b0;
            row_open_q  <= 1'b0;
            row_mode_q  <= MODE_64;
            err_q       <= 1'b0;
            tree_data_q <= '0;
            tree_vld_q  <= 1'b0;
            tree_mode_q <= MODE_64;
            acc_vld_q   <= 1'b0;
            for (int s = 0; s < TAG_STAGES; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            en_q        <= 1'b1;
            row_open_q  <= row_open_d;
            row_mode_q  <= row_mode_d;
            err_q       <= err_d;
            tree_data_q <= accept ? tree_data_d : '0;
            tree_vld_q  <= accept;
            if (accept) begin
                tree_mode_q <= cur_mode;
            end
            acc_vld_q   <= acc_vld_d;
            tag_q[0]    <= tag_d0;
            for (int s = 1; s < TAG_STAGES; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        acc_q <= acc_d;
    end

    max_sched_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (o_out_valid & i_out_ready),
        .data_o  (head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    // Head is masked while empty so stale storage never reaches the port.
    assign o_out_valid        = ~fifo_empty;
    assign o_out_max          = o_out_valid ? head[4*DATA_W-1:0] : '0;
    assign o_out_cnt          = o_out_valid ? head[RES_W-1 -: 3] : 3'd0;
    assign o_busy             = row_open_q | any_tag | o_out_valid;
    assign o_err              = err_q;
    assign o_tree_en          = en_q;
    assign o_tree_valid       = {LANES{tree_vld_q}};
    assign o_tree_in_flat     = tree_data_q;
    assign o_tree_length_mode = {2'b00, tree_mode_q};

endmodule

// File: tb/tb_max_tree_sched.sv
// Directed bench for max_tree_sched with a 6-cycle behavioural max tree.
module tb_max_tree_sched;
    import max_sched_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, in_last;
    logic [1023:0] in_data;
    logic [63:0]   in_mask;
    logic [3:0]    in_mode;
    logic          tree_en;
    logic [3:0]    tree_mode;
    logic [63:0]   tree_valid;
    logic [1023:0] tree_flat;
    logic          tv;
    logic signed [15:0] t64, t32_0, t32_1, t16_0, t16_1, t16_2, t16_3;
    logic          out_valid, out_ready, busy, err;
    logic [63:0]   out_max;
    logic [2:0]    out_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    max_tree_sched dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_in_valid         (in_valid),
        .o_in_ready         (in_ready),
        .i_in_data          (in_data),
        .i_in_mask          (in_mask),
        .i_in_last          (in_last),
        .i_in_mode          (in_mode),
        .o_tree_en          (tree_en),
        .o_tree_length_mode (tree_mode),
        .o_tree_valid       (tree_valid),
        .o_tree_in_flat     (tree_flat),
        .i_tree_valid_max   (tv),
        .i_tree_max64_0     (t64),
        .i_tree_max32_0     (t32_0),
        .i_tree_max32_1     (t32_1),
        .i_tree_max16_0     (t16_0),
        .i_tree_max16_1     (t16_1),
        .i_tree_max16_2     (t16_2),
        .i_tree_max16_3     (t16_3),
        .o_out_valid        (out_valid),
        .i_out_ready        (out_ready),
        .o_out_max          (out_max),
        .o_out_cnt          (out_cnt),
        .o_busy             (busy),
        .o_err              (err)
    );

    // Behavioural tree: every reduction computed each cycle, 6 register stages.
    logic signed [15:0] c16 [4];
    logic signed [15:0] c32 [2];
    logic signed [15:0] c64;
    logic               pv  [6];
    logic signed [15:0] p16 [6][4];

    always_comb begin
        for (int q = 0; q < 4; q++) begin
            c16[q] = tree_flat[q*256 +: 16];
            for (int j = 1; j < 16; j++) begin
                if ($signed(tree_flat[(q*16+j)*16 +: 16]) > c16[q])
                    c16[q] = tree_flat[(q*16+j)*16 +: 16];
            end
        end
        c32[0] = (c16[1] > c16[0]) ? c16[1] : c16[0];
        c32[1] = (c16[3] > c16[2]) ? c16[3] : c16[2];
        c64    = (c32[1] > c32[0]) ? c32[1] : c32[0];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 6; s++) begin
                pv[s] <= 1'b0;
                for (int q = 0; q < 4; q++) p16[s][q] <= '0;
            end
        end else begin
            pv[0] <= |tree_valid;
            for (int q = 0; q < 4; q++) p16[0][q] <= c16[q];
            for (int s = 1; s < 6; s++) begin
                pv[s] <= pv[s-1];
                for (int q = 0; q < 4; q++) p16[s][q] <= p16[s-1][q];
            end
        end
    end

    assign tv    = pv[5];
    assign t16_0 = p16[5][0];
    assign t16_1 = p16[5][1];
    assign t16_2 = p16[5][2];
    assign t16_3 = p16[5][3];
    assign t32_0 = (t16_1 > t16_0) ? t16_1 : t16_0;
    assign t32_1 = (t16_3 > t16_2) ? t16_3 : t16_2;
    assign t64   = (t32_1 > t32_0) ? t32_1 : t32_0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 64; i++) in_data[i*16 +: 16] = v;
    endtask

    task automatic send(input logic last, input logic [3:0] mode);
        int n = 0;
        in_last  = last;
        in_mode  = mode;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_arrive"}, out_valid, 1);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int  nacc;
    logic r;

    initial begin
        in_valid = 0; in_last = 0; in_mode = 0; in_data = '0; in_mask = '0; out_ready = 0;
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_tree_en", tree_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        #2 rst_n = 1'b1;
        tick();
        check("rel_tree_en", tree_en, 1);
        check("rel_in_ready", in_ready, 1);

        // Single 64-mode row, lane i = i-32
        for (int i = 0; i < 64; i++) in_data[i*16 +: 16] = 16'(i - 32);
        in_mask = '1;
        send(1'b1, 4'd0);
        check("t1_tree_vld", tree_valid, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_tree_mode", tree_mode, 0);
        tick();
        check("t1_bubble_vld", tree_valid, 0);
        check("t1_bubble_data", tree_flat[63:0], 0);
        repeat (5) tick();
        check("t1_early", out_valid, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_max", out_max, 64'd31);
        check("t1_cnt", out_cnt, 1);
        pop();
        check("t1_popped", out_valid, 0);

        // Three-beat row: 5, -3 (masked 200), 100
        fill(-16'sd10); in_data[15:0] = 16'd5; in_mask = '1;
        send(1'b0, 4'd0);
        fill(-16'sd20); in_data[2*16 +: 16] = -16'sd3; in_data[7*16 +: 16] = 16'd200;
        in_mask = ~(64'd1 << 7);
        send(1'b0, 4'd0);
        fill(-16'sd30); in_data[63*16 +: 16] = 16'd100; in_mask = '1;
        send(1'b1, 4'd0);
        repeat (6) tick();
        check("t2_early", out_valid, 0);
        tick();
        check("t2_valid", out_valid, 1);
        check("t2_max", out_max, 64'd100);
        check("t2_cnt", out_cnt, 1);
        pop();

        // 32-mode, upper half masked
        fill(-16'sd100); in_data[5*16 +: 16] = -16'sd7; in_mask = 64'h0000_0000_FFFF_FFFF;
        send(1'b1, 4'd1);
        check("t3_tree_mode", tree_mode, 1);
        check("t3_pad", tree_flat[40*16 +: 16], 16'h8000);
        check("t3_lane5", tree_flat[5*16 +: 16], 16'hFFF9);
        wait_out("t3");
        check("t3_max", out_max, 64'h0000_0000_8000_FFF9);
        check("t3_cnt", out_cnt, 2);
        pop();

        // 16-mode, quarter maxima 1..4
        fill(-16'sd5); in_mask = '1;
        in_data[0*256 +: 16] = 16'd1; in_data[1*256 +: 16] = 16'd2;
        in_data[2*256 +: 16] = 16'd3; in_data[3*256 +: 16] = 16'd4;
        send(1'b1, 4'd2);
        wait_out("t4");
        check("t4_max", out_max, 64'h0004_0003_0002_0001);
        check("t4_cnt", out_cnt, 4);
        pop();

        // Backpressure: sink stalled, stream single-beat rows
        in_data = '0; in_mask = 64'h1; in_last = 1; in_mode = 0; nacc = 0; in_valid = 1;
        for (int c = 0; c < 30; c++) begin
            r = in_ready;
            tick();
            if (r) begin
                nacc++;
                in_data[15:0] = 16'(nacc);
            end
        end
        in_valid = 0;
        check("t5_accepted", 64'(nacc), 8);
        check("t5_ready_low", in_ready, 0);
        check("t5_head_valid", out_valid, 1);
        check("t5_head0", out_max, 0);
        pop();
        check("t5_ready_back", in_ready, 1);
        for (int k = 1; k < 8; k++) begin
            check($sformatf("t5_order%0d", k), out_max, 64'(k));
            pop();
        end
        check("t5_drained", out_valid, 0);
        check("t5_idle", busy, 0);

        // Protocol errors
        check("t6_err_clean", err, 0);
        fill(16'hFFFF); in_data[10*16 +: 16] = 16'd42; in_mask = '1;
        send(1'b1, 4'd5);
        check("t6_err_set", err, 1);
        check("t6_mode_64", tree_mode, 0);
        wait_out("t6a");
        check("t6a_max", out_max, 64'd42);
        check("t6a_cnt", out_cnt, 1);
        pop();
        fill(16'hFFFF); in_data[15:0] = 16'd11; in_data[40*16 +: 16] = 16'd22;
        send(1'b0, 4'd1);
        wait_out("t6b");
        check("t6b_max", out_max, 64'h0000_0000_0016_000B);
        check("t6b_cnt", out_cnt, 2);
        pop();
        check("t6_row_closed", busy, 0);
        check("t6_err_sticky", err, 1);

        // Reset with four beats in flight
        fill(16'd50); in_mask = '1;
        for (int k = 0; k < 4; k++) send(1'b1, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t7_out_valid", out_valid, 0);
        check("t7_busy", busy, 0);
        check("t7_in_ready", in_ready, 0);
        check("t7_tree_en", tree_en, 0);
        check("t7_tree_vld", tree_valid, 0);
        check("t7_err", err, 0);
        check("t7_out_max", out_max, 0);
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        fill(16'd7);
        send(1'b1, 4'd0);
        repeat (6) tick();
        check("t7_early", out_valid, 0);
        tick();
        check("t7_valid", out_valid, 1);
        check("t7_max", out_max, 64'd7);
        pop();
        repeat (10) tick();
        check("t7_no_stale", out_valid, 0);
        check("t7_idle", busy, 0);
        check("t7_err_after", err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
